// File: rtl/pin_mux_pkg.sv
// Shared constants for the pin bank multiplexer: register map, select field
// geometry and guard counter sizing.
package pin_mux_pkg;

   localparam int unsigned AVL_ADDR_W    = 4;
   localparam int unsigned AVL_DATA_W    = 32;
   localparam int unsigned MSEL_FIELD_W  = 4;
   localparam int unsigned PINS_PER_WORD = 8;
   localparam int unsigned MSEL_WORDS    = 4;
   localparam int unsigned MAX_SRC       = 16;

   localparam logic [AVL_ADDR_W-1:0] ADDR_OUT        = 4'd0;
   localparam logic [AVL_ADDR_W-1:0] ADDR_DIR        = 4'd1;
   localparam logic [AVL_ADDR_W-1:0] ADDR_IN         = 4'd2;
   localparam logic [AVL_ADDR_W-1:0] ADDR_RISE_EN    = 4'd3;
   localparam logic [AVL_ADDR_W-1:0] ADDR_FALL_EN    = 4'd4;
   localparam logic [AVL_ADDR_W-1:0] ADDR_IRQ_STATUS = 4'd5;
   localparam logic [AVL_ADDR_W-1:0] ADDR_OUT_SET    = 4'd6;
   localparam logic [AVL_ADDR_W-1:0] ADDR_OUT_CLR    = 4'd7;
   localparam logic [AVL_ADDR_W-1:0] ADDR_MSEL0      = 4'd8;

   // Counter must hold the value GUARD_CYCLES itself.
   function automatic int unsigned guard_cnt_w(input int unsigned cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/pin_mux_guard.sv
// Per-pin select holder: on a select change the pin is held tristated for
// GUARD_CYCLES cycles, then the newest written select becomes active.
module pin_mux_guard
   import pin_mux_pkg::*;
#(
   parameter int unsigned GUARD_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [MSEL_FIELD_W-1:0] field,
   input  logic                    change,
   output logic [MSEL_FIELD_W-1:0] sel,
   output logic                    guard_active
);

   localparam int unsigned CNT_W = guard_cnt_w(GUARD_CYCLES);

   logic [CNT_W-1:0]        cnt_q;
   logic [MSEL_FIELD_W-1:0] sel_q;

   // A change reloads the counter; the select is adopted on the final count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         sel_q <= '0;
      end else if (change) begin
         cnt_q <= CNT_W'(GUARD_CYCLES);
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) sel_q <= field;
      end
   end

   assign sel          = sel_q;
   assign guard_active = (cnt_q != '0);

endmodule

// File: rtl/pin_mux_ctrl.sv
// Register-programmed pin bank multiplexer with select glitch guard, input
// synchronisers, per-pin edge interrupts and atomic output set/clear.
module pin_mux_ctrl
   import pin_mux_pkg::*;
#(
   parameter int unsigned PINS         = 32,
   parameter int unsigned FUNCS        = 4,
   parameter int unsigned GUARD_CYCLES = 4,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic                        iCLK,
   input  logic                        iRESETn,
   input  logic [AVL_ADDR_W-1:0]       iAVL_ADDRESS,
   input  logic                        iAVL_WRITE,
   input  logic [AVL_DATA_W-1:0]       iAVL_WRITEDATA,
   input  logic                        iAVL_READ,
   output logic [AVL_DATA_W-1:0]       oAVL_READDATA,
   input  logic [PINS-1:0]             iPIN_I,
   output logic [PINS-1:0]             oPIN_O,
   output logic [PINS-1:0]             oPIN_OE,
   output logic [PINS-1:0]             oPIN_SYNC,
   input  logic [(FUNCS-1)*PINS-1:0]   iALT_O,
   input  logic [(FUNCS-1)*PINS-1:0]   iALT_OE,
   output logic                        oIRQ
);

   logic [PINS-1:0]                  out_q, dir_q, rise_q, fall_q, status_q, prev_q;
   logic [SYNC_STAGES-1:0][PINS-1:0] sync_q;
   logic [PINS-1:0][MSEL_FIELD_W-1:0] msel_q;
   logic                             irq_q;
   logic [AVL_DATA_W-1:0]            rdata_q, rd_c;
   logic [MSEL_WORDS-1:0][AVL_DATA_W-1:0] msel_words;
   logic [PINS-1:0]                  wd, sync_last, edge_set, w1c_mask;
   logic [PINS-1:0][MSEL_FIELD_W-1:0] msel_wfield, eff_sel;
   logic [PINS-1:0]                  msel_wr, msel_change, guard_active;

   assign wd        = iAVL_WRITEDATA[PINS-1:0];
   assign sync_last = sync_q[SYNC_STAGES-1];
   assign w1c_mask  = (iAVL_WRITE && iAVL_ADDRESS == ADDR_IRQ_STATUS) ? wd : '0;
   assign edge_set  = (sync_last & ~prev_q & rise_q) | (~sync_last & prev_q & fall_q);

   always_ff @(posedge iCLK or negedge iRESETn) begin
      if (!iRESETn) begin
         out_q    <= '0;
         dir_q    <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
         status_q <= '0;
         prev_q   <= '0;
         sync_q   <= '0;
         msel_q   <= '0;
         irq_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         if (iAVL_WRITE) begin
            unique case (iAVL_ADDRESS)
               ADDR_OUT:     out_q  <= wd;
               ADDR_OUT_SET: out_q  <= out_q | wd;
               ADDR_OUT_CLR: out_q  <= out_q & ~wd;
               ADDR_DIR:     dir_q  <= wd;
               ADDR_RISE_EN: rise_q <= wd;
               ADDR_FALL_EN: fall_q <= wd;
               default: ;
            endcase
         end
         for (int p = 0; p < PINS; p++) begin
            if (msel_wr[p]) msel_q[p] <= msel_wfield[p];
         end
         // A new edge in the same cycle as its clear keeps the bit set.
         status_q <= (status_q & ~w1c_mask) | edge_set;
         irq_q    <= |status_q;
         if (SYNC_STAGES > 1) sync_q <= {sync_q[SYNC_STAGES-2:0], iPIN_I};
         else                 sync_q <= iPIN_I;
         prev_q   <= sync_last;
         if (iAVL_READ) rdata_q <= rd_c;
      end
   end

   // Per-pin select write decode, readback packing and output source mux.
   for (genvar p = 0; p < MSEL_WORDS * PINS_PER_WORD; p++) begin : g_slot
      localparam int unsigned LSB = MSEL_FIELD_W * (p % PINS_PER_WORD);
      if (p < PINS) begin : g_pin
         logic [MAX_SRC-1:0] src_o, src_oe;

         assign msel_wfield[p] = iAVL_WRITEDATA[LSB +: MSEL_FIELD_W];
         assign msel_wr[p]     = iAVL_WRITE &&
                                 (iAVL_ADDRESS == AVL_ADDR_W'(32'(ADDR_MSEL0) + p / PINS_PER_WORD));
         assign msel_change[p] = msel_wr[p] && (msel_wfield[p] != msel_q[p]);
         assign msel_words[p / PINS_PER_WORD][LSB +: MSEL_FIELD_W] = msel_q[p];

         pin_mux_guard #(.GUARD_CYCLES(GUARD_CYCLES)) u_guard (
            .clk          (iCLK),
            .rst_n        (iRESETn),
            .field        (msel_q[p]),
            .change       (msel_change[p]),
            .sel          (eff_sel[p]),
            .guard_active (guard_active[p])
         );

         // Source 0 is PIO; unimplemented selects read as a safe tristate.
         for (genvar f = 0; f < MAX_SRC; f++) begin : g_src
            if (f == 0) begin : g_pio
               assign src_o[f]  = out_q[p];
               assign src_oe[f] = dir_q[p];
            end else if (f < FUNCS) begin : g_alt
               assign src_o[f]  = iALT_O[(f-1)*PINS + p];
               assign src_oe[f] = iALT_OE[(f-1)*PINS + p];
            end else begin : g_off
               assign src_o[f]  = 1'b0;
               assign src_oe[f] = 1'b0;
            end
         end

         assign oPIN_O[p]  = src_o[eff_sel[p]]  & ~guard_active[p];
         assign oPIN_OE[p] = src_oe[eff_sel[p]] & ~guard_active[p];
      end else begin : g_none
         assign msel_words[p / PINS_PER_WORD][LSB +: MSEL_FIELD_W] = '0;
      end
   end

   always_comb begin
      rd_c = '0;
      unique case (iAVL_ADDRESS)
         ADDR_OUT:        rd_c[PINS-1:0] = out_q;
         ADDR_DIR:        rd_c[PINS-1:0] = dir_q;
         ADDR_IN:         rd_c[PINS-1:0] = sync_last;
         ADDR_RISE_EN:    rd_c[PINS-1:0] = rise_q;
         ADDR_FALL_EN:    rd_c[PINS-1:0] = fall_q;
         ADDR_IRQ_STATUS: rd_c[PINS-1:0] = status_q;
         default: begin
            if (iAVL_ADDRESS[3:2] == 2'b10) rd_c = msel_words[iAVL_ADDRESS[1:0]];
         end
      endcase
   end

   assign oAVL_READDATA = rdata_q;
   assign oPIN_SYNC     = sync_last;
   assign oIRQ          = irq_q;

endmodule

// File: tb/tb_pin_mux_ctrl.sv
// Scoreboard bench for pin_mux_ctrl: register reads are checked against a
// queue of expected values; pad-side behaviour is checked cycle by cycle.
module tb_pin_mux_ctrl;
   import pin_mux_pkg::*;

   localparam int unsigned PINS  = 32;
   localparam int unsigned FUNCS = 4;
   localparam int unsigned GUARD = 4;
   localparam int unsigned SYNC  = 2;
   localparam int unsigned ALT_W = (FUNCS-1)*PINS;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [3:0]       avl_addr = '0;
   logic             avl_write = 1'b0;
   logic [31:0]      avl_wdata = '0;
   logic             avl_read = 1'b0;
   logic [31:0]      avl_rdata;
   logic [PINS-1:0]  pin_i = '0;
   logic [PINS-1:0]  pin_o, pin_oe, pin_sync;
   logic [ALT_W-1:0] alt_o = '0;
   logic [ALT_W-1:0] alt_oe = '0;
   logic             irq;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_t;

   sb_t         sb_q[$];
   logic        rd_valid = 1'b0;
   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   pin_mux_ctrl #(
      .PINS(PINS), .FUNCS(FUNCS), .GUARD_CYCLES(GUARD), .SYNC_STAGES(SYNC)
   ) dut (
      .iCLK           (clk),
      .iRESETn        (rst_n),
      .iAVL_ADDRESS   (avl_addr),
      .iAVL_WRITE     (avl_write),
      .iAVL_WRITEDATA (avl_wdata),
      .iAVL_READ      (avl_read),
      .oAVL_READDATA  (avl_rdata),
      .iPIN_I         (pin_i),
      .oPIN_O         (pin_o),
      .oPIN_OE        (pin_oe),
      .oPIN_SYNC      (pin_sync),
      .iALT_O         (alt_o),
      .iALT_OE        (alt_oe),
      .oIRQ           (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      avl_addr  = a;
      avl_wdata = d;
      avl_write = 1'b1;
      @(posedge clk);
      #1 avl_write = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
      avl_addr = a;
      avl_read = 1'b1;
      sb_q.push_back('{tag, exp});
      @(posedge clk);
      #1 avl_read = 1'b0;
   endtask

   // Read data is due one edge after the read is accepted.
   always @(posedge clk) rd_valid <= avl_read && rst_n;

   always @(negedge clk) begin
      sb_t e;
      if (rd_valid) begin
         if (sb_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
         else begin
            e = sb_q.pop_front();
            check(e.tag, avl_rdata, e.exp);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state and register map.
      repeat (3) @(negedge clk);
      check("rst_oe", pin_oe, 32'h0);
      check("rst_irq", irq, 32'h0);
      rst_n = 1'b1;
      for (int a = 0; a < 12; a++) rd(4'(a), 32'h0, $sformatf("rst_rd%0d", a));
      @(negedge clk);
      check("rst_o", pin_o, 32'h0);

      // PIO output with atomic set/clear.
      wr(ADDR_DIR, 32'h1);
      wr(ADDR_OUT, 32'h1);
      @(negedge clk);
      check("pio_oe", pin_oe, 32'h1);
      check("pio_o_hi", pin_o[0], 32'h1);
      wr(ADDR_OUT_CLR, 32'h1);
      @(negedge clk);
      check("out_clr", pin_o[0], 32'h0);
      wr(ADDR_OUT_SET, 32'h3);
      @(negedge clk);
      check("out_set", pin_o[0], 32'h1);
      check("pin1_oe", pin_oe[1], 32'h0);
      rd(ADDR_OUT, 32'h3, "out_rb");
      rd(ADDR_OUT_SET, 32'h0, "set_rb");
      rd(ADDR_OUT_CLR, 32'h0, "clr_rb");
      // Write and read of the same register in one cycle returns the old value.
      avl_addr  = ADDR_DIR;
      avl_wdata = 32'h21;
      avl_write = 1'b1;
      avl_read  = 1'b1;
      sb_q.push_back('{"rw_same", 32'h1});
      @(posedge clk);
      #1 avl_write = 1'b0;
      avl_read = 1'b0;
      rd(ADDR_DIR, 32'h21, "dir_rb");
      @(negedge clk);

      // Pin 5: PIO high, then switch to function 1 through the guard.
      wr(ADDR_OUT_SET, 32'h20);
      alt_oe[5] = 1'b1;
      alt_o[5]  = 1'b1;
      @(negedge clk);
      check("pin5_pio_oe", pin_oe[5], 32'h1);
      wr(ADDR_MSEL0, 32'h0010_0000);
      for (int i = 0; i < GUARD; i++) begin
         @(negedge clk);
         check("guard_oe5", pin_oe[5], 32'h0);
         check("guard_o5", pin_o[5], 32'h0);
      end
      check("guard_pin0_oe", pin_oe[0], 32'h1);
      @(negedge clk);
      check("alt1_oe5", pin_oe[5], 32'h1);
      alt_o[5] = 1'b0;
      #1 check("alt1_o5", pin_o[5], 32'h0);
      alt_o[5] = 1'b1;
      wr(ADDR_MSEL0, 32'h0010_0000);
      for (int i = 0; i <= GUARD; i++) begin
         @(negedge clk);
         check("same_nogap", pin_oe[5], 32'h1);
      end

      // Pin 3: change during a guard restarts it; out-of-range select tristates.
      alt_oe[3]        = 1'b1;
      alt_o[3]         = 1'b1;
      alt_oe[PINS + 3] = 1'b1;
      alt_o[PINS + 3]  = 1'b0;
      wr(ADDR_MSEL0, 32'h0010_2000);
      repeat (2) begin
         @(negedge clk);
         check("first_guard_oe3", pin_oe[3], 32'h0);
      end
      wr(ADDR_MSEL0, 32'h0010_1000);
      for (int i = 0; i < GUARD; i++) begin
         @(negedge clk);
         check("restart_oe3", pin_oe[3], 32'h0);
         check("restart_oe5", pin_oe[5], 32'h1);
      end
      @(negedge clk);
      check("alt1_oe3", pin_oe[3], 32'h1);
      check("alt1_o3", pin_o[3], 32'h1);
      wr(ADDR_MSEL0, 32'h0010_9000);
      rd(ADDR_MSEL0, 32'h0010_9000, "msel_rb");
      rd(4'(ADDR_MSEL0 + 4'd1), 32'h0, "msel1_rb");
      repeat (GUARD + 2) @(negedge clk);
      check("sel9_oe3", pin_oe[3], 32'h0);
      check("sel9_o3", pin_o[3], 32'h0);

      // Pin 8 rising-edge interrupt latency.
      wr(ADDR_RISE_EN, 32'h100);
      @(posedge clk);
      #1 pin_i[8] = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         check($sformatf("sync8_t%0d", i), pin_sync[8], (i >= 3) ? 32'h1 : 32'h0);
         check($sformatf("irq_t%0d", i), irq, (i >= 5) ? 32'h1 : 32'h0);
      end
      rd(ADDR_IN, 32'h100, "in_rb");
      rd(ADDR_IRQ_STATUS, 32'h100, "status_rb");
      pin_i[8] = 1'b0;
      repeat (4) @(posedge clk);
      #1 pin_i[8] = 1'b1;
      repeat (2) @(posedge clk);
      #1 wr(ADDR_IRQ_STATUS, 32'h100);
      rd(ADDR_IRQ_STATUS, 32'h100, "w1c_vs_edge");
      wr(ADDR_RISE_EN, 32'h0);
      rd(ADDR_IRQ_STATUS, 32'h100, "en_clr_keeps");
      wr(ADDR_IRQ_STATUS, 32'h100);
      rd(ADDR_IRQ_STATUS, 32'h0, "w1c_clr");
      @(negedge clk);
      check("irq_clr", irq, 32'h0);

      // Asynchronous reset in the middle of a guard with a pending interrupt.
      wr(ADDR_RISE_EN, 32'h100);
      pin_i[8] = 1'b0;
      repeat (4) @(negedge clk);
      pin_i[8] = 1'b1;
      repeat (6) @(negedge clk);
      check("irq_pre_rst", irq, 32'h1);
      rd(ADDR_DIR, 32'h21, "dir_pre_rst");
      @(negedge clk);
      wr(ADDR_MSEL0, 32'h0020_9000);
      @(negedge clk);
      check("pre_rst_oe0", pin_oe[0], 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_oe", pin_oe, 32'h0);
      check("arst_o", pin_o, 32'h0);
      check("arst_irq", irq, 32'h0);
      check("arst_rdata", avl_rdata, 32'h0);
      check("arst_sync", pin_sync, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (GUARD + 2) @(negedge clk);
      check("post_rst_oe", pin_oe, 32'h0);
      check("post_rst_irq", irq, 32'h0);
      rd(ADDR_MSEL0, 32'h0, "post_rst_msel");
      rd(ADDR_DIR, 32'h0, "post_rst_dir");
      rd(ADDR_IRQ_STATUS, 32'h0, "post_rst_status");
      rd(ADDR_IN, 32'h100, "post_rst_in");
      wr(ADDR_DIR, 32'h20);
      @(negedge clk);
      check("pio_after_rst", pin_oe, 32'h20);

      @(negedge clk);
      check("sb_drain", sb_q.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pin_mux_ctrl.md
Name: pin_mux_ctrl

Overview:
Parametrised, register-programmed pin multiplexer for one MKR/NINA/PEX pin bank. Each pin's output and output-enable come from one of three sources, chosen per pin: a PIO register, one of FUNCS-1 alternate peripheral functions, or a safe tristate.
Adds a glitch guard on function change, input synchronisers, per-pin edge interrupts, and atomic set/clear of output bits.
Sits between the system interconnect (Avalon-MM slave) and the top-level tristate pad assigns, and replaces the hand-written per-bank generate muxes.

Parameters:
- PINS, 32, number of pins in the bank (1..32).
- FUNCS, 4, number of sources including PIO (2..16); select 0 = PIO, selects 1..FUNCS-1 = alternate functions.
- GUARD_CYCLES, 4, tristate hold cycles after a pin's select field changes (1..15).
- SYNC_STAGES, 2, input synchroniser depth (2..4).

Ports:
- iCLK  in  1  bank clock.
- iRESETn  in  1  asynchronous active-low reset.
- iAVL_ADDRESS  in  4  word address.
- iAVL_WRITE  in  1  write strobe.
- iAVL_WRITEDATA  in  32  write data.
- iAVL_READ  in  1  read strobe.
- oAVL_READDATA  out  32  read data, registered.
- iPIN_I  in  PINS  raw pad inputs.
- oPIN_O  out  PINS  pad output value.
- oPIN_OE  out  PINS  pad output enable; top level drives 1'bz when low.
- oPIN_SYNC  out  PINS  synchronised pad inputs for alternate peripherals.
- iALT_O  in  (FUNCS-1)*PINS  alternate outputs; function f at slice [(f-1)*PINS +: PINS].
- iALT_OE  in  (FUNCS-1)*PINS  alternate output enables, same packing.
- oIRQ  out  1  level interrupt, registered.

Behaviour:
- Register map (word addresses); writes have no wait states; read latency 1 cycle; unmapped reads return 0; bits at or above PINS read 0 and ignore writes.
  - 0 OUT (rw)
  - 1 DIR (rw, 1 = output)
  - 2 IN (ro, synchronised)
  - 3 RISE_EN (rw)
  - 4 FALL_EN (rw)
  - 5 IRQ_STATUS (W1C)
  - 6 OUT_SET (wo, write-1-set OUT)
  - 7 OUT_CLR (wo, write-1-clear OUT)
  - 8..11 MSEL: 4-bit field per pin, 8 pins per word; pin p is word 8+p/8, bits [4*(p%8)+:4].
- Reset values: all registers 0, so every pin is PIO input. oPIN_OE=0, oPIN_O=0, oIRQ=0, oAVL_READDATA=0, oPIN_SYNC=0, guard counters 0.
- Output mux is combinational from registered state and live alternate inputs:
  - guard active: OE=0, O=0.
  - sel=0: OE=DIR[p], O=OUT[p].
  - 1<=sel<FUNCS: OE=iALT_OE, O=iALT_O of function sel.
  - sel>=FUNCS: OE=0, O=0.
- Guard, per pin:
  - A write that changes a pin's MSEL field loads that pin's counter with GUARD_CYCLES on the next edge.
  - While the counter is nonzero, the pin is in the guard state and the counter decrements each cycle.
  - The new select takes effect on the cycle the counter reaches 0, i.e. the pin is tristated for exactly GUARD_CYCLES cycles.
  - A write of an identical value does not start a guard.
  - A change written during a guard reloads the counter.
  - MSEL readback always returns the newest written value.
- Input path:
  - SYNC_STAGES flops feed oPIN_SYNC and IN.
  - One further flop holds the previous value for edge detection.
  - A pad change at clock k appears in IN at k+SYNC_STAGES; the STATUS bit sets at k+SYNC_STAGES+1; oIRQ asserts at k+SYNC_STAGES+2.
- IRQ:
  - STATUS[p] sets on a rising edge when RISE_EN[p] is set, and on a falling edge when FALL_EN[p] is set.
  - Edges are detected regardless of MSEL or DIR.
  - A W1C clear and a new edge in the same cycle: set wins.
  - oIRQ = OR of STATUS, registered.
  - Clearing an enable does not clear STATUS.
- OUT_SET and OUT_CLR modify OUT in the cycle after the write, identically to a read-modify-write; both read 0.
- Write and read to the same address in the same cycle: the read returns the old value.
- Reset asserted mid-guard or mid-transfer: everything returns to reset values immediately (asynchronous); no pending state survives.

Decomposition:
- Package pin_mux_pkg:
  - register address localparams (ADDR_OUT..ADDR_MSEL0)
  - MSEL_FIELD_W=4
  - PINS_PER_WORD=8
  - a function computing the guard counter width.
- Sub-module pin_mux_guard, instantiated per pin via generate:
  - holds that pin's active select and guard counter
  - inputs: written field, change strobe
  - outputs: effective select, guard_active.

Test Plan:
1. Reset, then read addresses 0..11 -> all 0; oPIN_OE=0; oIRQ=0.
2. Write DIR=0x1, OUT=0x1, then OUT_CLR=0x1, OUT_SET=0x3 -> pin0 OE=1, O toggles 1->0->1; OUT reads 0x3; pin1 OE stays 0.
3. PINS=32, FUNCS=4, GUARD_CYCLES=4: pin5 PIO output high; write MSEL word0=0x0010_0000 with iALT_OE/iALT_O of function 1 high on pin5 -> pin5 OE=0 for exactly 4 cycles, then driven by function 1. Rewriting the same value -> no gap.
4. Write pin3 select 2, then select 1 two cycles into the guard -> guard restarts; pin3 ends on function 1 after 4 cycles from the second write. Select 9 -> pin3 permanently OE=0.
5. RISE_EN=0x100; pulse iPIN_I[8] high at clock k -> IN[8] at k+2, STATUS[8] at k+3, oIRQ at k+4. W1C 0x100 in the same cycle as a new rising edge -> STATUS stays 1.
6. Assert iRESETn low mid-guard with STATUS nonzero -> all outputs 0 asynchronously; after release, pins are PIO inputs with no pending guard.
